// File: rtl/rbt_s_hdr_arbiter_if.sv
// Bundle between the proto-header sources, the arbiter and the pre-parser.
// Carries the per-source request buses, the single output stream and arbiter debug state.
interface rbt_s_hdr_arbiter_if #(
    parameter int PORTS        = 4,
    parameter int HEADER_WIDTH = 2048,
    parameter int USER_WIDTH   = 56,
    parameter int META_WIDTH   = 32,
    parameter int SEL_WIDTH    = $clog2(PORTS)
);
    // Handshake: a transfer happens on a cycle where valid and ready are both high.
    // Producers hold payload stable while valid is high and not yet accepted; ready never
    // waits on the producer's own valid (beyond request masking).
    logic [PORTS-1:0]              in_proto_hdr_valid;
    logic [PORTS-1:0]              in_proto_hdr_ready;
    logic [PORTS*16-1:0]           in_proto_hdr_length;
    logic [PORTS*16-1:0]           in_proto_hdr_pktlen;
    logic [PORTS*HEADER_WIDTH-1:0] in_proto_hdr_data;
    logic [PORTS*USER_WIDTH-1:0]   in_proto_hdr_tuser;
    logic [PORTS*META_WIDTH-1:0]   in_proto_hdr_meta;
    logic [PORTS-1:0]              port_enable;

    logic                          out_proto_hdr_valid;
    logic                          out_proto_hdr_ready;
    logic [15:0]                   out_proto_hdr_length;
    logic [15:0]                   out_proto_hdr_pktlen;
    logic [HEADER_WIDTH-1:0]       out_proto_hdr_data;
    logic [USER_WIDTH-1:0]         out_proto_hdr_tuser;
    logic [META_WIDTH-1:0]         out_proto_hdr_meta;
    logic [SEL_WIDTH-1:0]          out_proto_hdr_sel;

    logic [SEL_WIDTH-1:0]          dbg_last_grant;
    logic [7:0]                    dbg_burst_cnt;

    modport slave (
        input  in_proto_hdr_valid, in_proto_hdr_length, in_proto_hdr_pktlen,
        input  in_proto_hdr_data, in_proto_hdr_tuser, in_proto_hdr_meta, port_enable,
        output in_proto_hdr_ready,
        output out_proto_hdr_valid, out_proto_hdr_length, out_proto_hdr_pktlen,
        output out_proto_hdr_data, out_proto_hdr_tuser, out_proto_hdr_meta, out_proto_hdr_sel,
        input  out_proto_hdr_ready,
        output dbg_last_grant, dbg_burst_cnt
    );

    modport master (
        output in_proto_hdr_valid, in_proto_hdr_length, in_proto_hdr_pktlen,
        output in_proto_hdr_data, in_proto_hdr_tuser, in_proto_hdr_meta, port_enable,
        input  in_proto_hdr_ready,
        input  out_proto_hdr_valid, out_proto_hdr_length, out_proto_hdr_pktlen,
        input  out_proto_hdr_data, out_proto_hdr_tuser, out_proto_hdr_meta, out_proto_hdr_sel,
        output out_proto_hdr_ready,
        input  dbg_last_grant, dbg_burst_cnt
    );
endinterface

// File: rtl/rbt_s_hdr_arbiter.sv
// Round-robin arbiter with bounded bursts, merging PORTS proto-header sources into one
// registered stream for the pre-parser; optionally tags tuser[7:0] with the winning index.
module rbt_s_hdr_arbiter #(
    parameter int PORTS        = 4,
    parameter int HEADER_WIDTH = 2048,
    parameter int USER_WIDTH   = 56,
    parameter int META_WIDTH   = 32,
    parameter int MAX_BURST    = 4,
    parameter int TAG_INPORT   = 1,
    parameter int SEL_WIDTH    = $clog2(PORTS)
) (
    input logic                 clk,
    input logic                 rst,
    rbt_s_hdr_arbiter_if.slave  hdr
);
    logic [PORTS-1:0]        req;
    logic                    free;
    logic                    grant_cont;
    logic                    grant_vld;
    logic                    accept;
    logic [SEL_WIDTH-1:0]    grant_idx;
    logic [SEL_WIDTH-1:0]    cand;
    logic [SEL_WIDTH-1:0]    last_grant;
    logic [7:0]              burst_cnt;
    logic [USER_WIDTH-1:0]   tuser_next;

    logic                    out_valid_q;
    logic [15:0]             out_length_q;
    logic [15:0]             out_pktlen_q;
    logic [HEADER_WIDTH-1:0] out_data_q;
    logic [USER_WIDTH-1:0]   out_tuser_q;
    logic [META_WIDTH-1:0]   out_meta_q;
    logic [SEL_WIDTH-1:0]    out_sel_q;

    assign req  = hdr.in_proto_hdr_valid & hdr.port_enable;
    assign free = !out_valid_q || hdr.out_proto_hdr_ready;

    // burst_cnt == 0 means no burst is open (after reset), so the first grant rotates from PORTS-1 to 0.
    assign grant_cont = req[last_grant] && (burst_cnt != 8'd0) && (burst_cnt < 8'(MAX_BURST));

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant;
        cand      = last_grant;
        if (grant_cont) begin
            grant_vld = 1'b1;
        end else begin
            for (int i = 1; i <= PORTS; i++) begin
                cand = SEL_WIDTH'((32'(last_grant) + 32'(i)) % 32'(PORTS));
                if (!grant_vld && req[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign accept = free && grant_vld && !rst;
    assign hdr.in_proto_hdr_ready = accept ? (PORTS'(1) << grant_idx) : '0;

    always_comb begin
        tuser_next = hdr.in_proto_hdr_tuser[grant_idx*USER_WIDTH +: USER_WIDTH];
        if (TAG_INPORT == 1) tuser_next[7:0] = 8'(grant_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_length_q <= '0;
            out_pktlen_q <= '0;
            out_data_q   <= '0;
            out_tuser_q  <= '0;
            out_meta_q   <= '0;
            out_sel_q    <= '0;
            last_grant   <= SEL_WIDTH'(PORTS - 1);
            burst_cnt    <= 8'd0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_length_q <= hdr.in_proto_hdr_length[grant_idx*16 +: 16];
            out_pktlen_q <= hdr.in_proto_hdr_pktlen[grant_idx*16 +: 16];
            out_data_q   <= hdr.in_proto_hdr_data[grant_idx*HEADER_WIDTH +: HEADER_WIDTH];
            out_tuser_q  <= tuser_next;
            out_meta_q   <= hdr.in_proto_hdr_meta[grant_idx*META_WIDTH +: META_WIDTH];
            out_sel_q    <= grant_idx;
            last_grant   <= grant_idx;
            // A grant reached by rotation opens a fresh burst, even if it wrapped back to the same source.
            if (grant_cont)
                burst_cnt <= (burst_cnt >= 8'(MAX_BURST)) ? 8'(MAX_BURST) : burst_cnt + 8'd1;
            else
                burst_cnt <= 8'd1;
        end else if (hdr.out_proto_hdr_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign hdr.out_proto_hdr_valid  = out_valid_q;
    assign hdr.out_proto_hdr_length = out_length_q;
    assign hdr.out_proto_hdr_pktlen = out_pktlen_q;
    assign hdr.out_proto_hdr_data   = out_data_q;
    assign hdr.out_proto_hdr_tuser  = out_tuser_q;
    assign hdr.out_proto_hdr_meta   = out_meta_q;
    assign hdr.out_proto_hdr_sel    = out_sel_q;
    assign hdr.dbg_last_grant       = last_grant;
    assign hdr.dbg_burst_cnt        = burst_cnt;
endmodule

// File: tb/tb_rbt_s_hdr_arbiter.sv
// Bench for rbt_s_hdr_arbiter: two instances (MAX_BURST=1 and 4) share one stimulus;
// a vector table covers rotation/burst/masking, hand sequences cover stall, idle and reset.
module tb_rbt_s_hdr_arbiter;
    localparam int PORTS = 4;
    localparam int HW    = 64;
    localparam int UW    = 16;
    localparam int MW    = 8;
    localparam int SW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [PORTS-1:0]    valid;
    logic [PORTS-1:0]    en;
    logic                oready;
    logic [PORTS*16-1:0] len_bus;
    logic [PORTS*16-1:0] pkt_bus;
    logic [PORTS*HW-1:0] data_bus;
    logic [PORTS*UW-1:0] tuser_bus;
    logic [PORTS*MW-1:0] meta_bus;

    int checks = 0;
    int errors = 0;

    rbt_s_hdr_arbiter_if #(.PORTS(PORTS), .HEADER_WIDTH(HW), .USER_WIDTH(UW), .META_WIDTH(MW)) if1 ();
    rbt_s_hdr_arbiter_if #(.PORTS(PORTS), .HEADER_WIDTH(HW), .USER_WIDTH(UW), .META_WIDTH(MW)) if4 ();

    assign if1.in_proto_hdr_valid  = valid;
    assign if1.port_enable         = en;
    assign if1.out_proto_hdr_ready = oready;
    assign if1.in_proto_hdr_length = len_bus;
    assign if1.in_proto_hdr_pktlen = pkt_bus;
    assign if1.in_proto_hdr_data   = data_bus;
    assign if1.in_proto_hdr_tuser  = tuser_bus;
    assign if1.in_proto_hdr_meta   = meta_bus;
    assign if4.in_proto_hdr_valid  = valid;
    assign if4.port_enable         = en;
    assign if4.out_proto_hdr_ready = oready;
    assign if4.in_proto_hdr_length = len_bus;
    assign if4.in_proto_hdr_pktlen = pkt_bus;
    assign if4.in_proto_hdr_data   = data_bus;
    assign if4.in_proto_hdr_tuser  = tuser_bus;
    assign if4.in_proto_hdr_meta   = meta_bus;

    rbt_s_hdr_arbiter #(.PORTS(PORTS), .HEADER_WIDTH(HW), .USER_WIDTH(UW), .META_WIDTH(MW),
                        .MAX_BURST(1), .TAG_INPORT(1)) u_dut_b1 (.clk(clk), .rst(rst), .hdr(if1));
    rbt_s_hdr_arbiter #(.PORTS(PORTS), .HEADER_WIDTH(HW), .USER_WIDTH(UW), .META_WIDTH(MW),
                        .MAX_BURST(4), .TAG_INPORT(1)) u_dut_b4 (.clk(clk), .rst(rst), .hdr(if4));

    typedef struct {
        logic [3:0] valid;
        logic [3:0] en;
        logic [1:0] sel1;
        logic [1:0] sel4;
    } vec_t;
    vec_t vecs[$];

    // Expected payload per source: tuser low byte is replaced by the source index.
    function automatic logic [127:0] exp_pay(input logic [1:0] s);
        logic [15:0] len, pkt, tu;
        logic [63:0] d;
        logic [7:0]  me;
        len = 16'h0100 + 16'(s);
        pkt = 16'h0200 + 16'(s);
        d   = 64'hDA7A_0000_C0DE_0000 + 64'(s) * 64'h0001_0001_0001_0001;
        tu  = {8'h60 + 8'(s), 8'(s)};
        me  = 8'hE0 + 8'(s);
        return {24'h0, len, pkt, d, tu, me};
    endfunction

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [1:0] sel,
                             input logic [15:0] len, input logic [15:0] pkt, input logic [63:0] d,
                             input logic [15:0] tu, input logic [7:0] me, input logic [1:0] exp_sel);
        check_eq({name, "_valid"}, 128'(v), 128'(1));
        check_eq({name, "_sel"}, 128'(sel), 128'(exp_sel));
        check_eq({name, "_payload"}, {24'h0, len, pkt, d, tu, me}, exp_pay(exp_sel));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] e, input logic [1:0] s1, input logic [1:0] s4);
        vecs.push_back('{valid: v, en: e, sel1: s1, sel4: s4});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] s1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [1:0] s4 [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        logic [1:0] b1 [8] = '{1, 2, 1, 2, 1, 2, 1, 2};
        logic [1:0] b4 [8] = '{2, 2, 2, 2, 1, 1, 1, 1};
        logic [1:0] c1 [4] = '{3, 0, 1, 3};
        for (int i = 0; i < 8; i++) add(4'hF, 4'hF, s1[i], s4[i]);
        for (int i = 0; i < 8; i++) add(4'h6, 4'hF, b1[i], b4[i]);
        for (int i = 0; i < 4; i++) add(4'hF, 4'hB, c1[i], 2'd3);
        for (int i = 0; i < 4; i++) add(4'h8, 4'hF, 2'd3, 2'd3);

        for (int s = 0; s < PORTS; s++) begin
            len_bus[s*16 +: 16]   = 16'h0100 + 16'(s);
            pkt_bus[s*16 +: 16]   = 16'h0200 + 16'(s);
            data_bus[s*HW +: HW]  = 64'hDA7A_0000_C0DE_0000 + 64'(s) * 64'h0001_0001_0001_0001;
            tuser_bus[s*UW +: UW] = {8'h60 + 8'(s), 8'hAA};
            meta_bus[s*MW +: MW]  = 8'hE0 + 8'(s);
        end
        valid  = 4'hF;
        en     = 4'hF;
        oready = 1'b1;

        // Reset state, with every source requesting.
        step();
        step();
        check_eq("rst_out_b1", {if1.out_proto_hdr_valid, if1.out_proto_hdr_sel, if1.out_proto_hdr_data}, '0);
        check_eq("rst_out_b4", {if4.out_proto_hdr_valid, if4.out_proto_hdr_sel, if4.out_proto_hdr_tuser}, '0);
        check_eq("rst_ready_b1", 128'(if1.in_proto_hdr_ready), 128'(0));
        check_eq("rst_ready_b4", 128'(if4.in_proto_hdr_ready), 128'(0));
        rst = 1'b0;
        #1;
        check_eq("first_ready_b1", 128'(if1.in_proto_hdr_ready), 128'(4'b0001));
        check_eq("first_ready_b4", 128'(if4.in_proto_hdr_ready), 128'(4'b0001));

        foreach (vecs[i]) begin
            valid = vecs[i].valid;
            en    = vecs[i].en;
            step();
            check_out($sformatf("vec%0d_b1", i), if1.out_proto_hdr_valid, if1.out_proto_hdr_sel,
                      if1.out_proto_hdr_length, if1.out_proto_hdr_pktlen, if1.out_proto_hdr_data,
                      if1.out_proto_hdr_tuser, if1.out_proto_hdr_meta, vecs[i].sel1);
            check_out($sformatf("vec%0d_b4", i), if4.out_proto_hdr_valid, if4.out_proto_hdr_sel,
                      if4.out_proto_hdr_length, if4.out_proto_hdr_pktlen, if4.out_proto_hdr_data,
                      if4.out_proto_hdr_tuser, if4.out_proto_hdr_meta, vecs[i].sel4);
            check_eq($sformatf("vec%0d_masked_ready", i),
                     128'({if1.in_proto_hdr_ready & ~en, if4.in_proto_hdr_ready & ~en}), 128'(0));
        end
        check_eq("burst_restart_b4", 128'({if4.dbg_last_grant, if4.dbg_burst_cnt}), 128'({2'd3, 8'd4}));

        // Stall: outputs hold on source 3, no ready anywhere.
        valid  = 4'hF;
        oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("stall%0d_b1", i), if1.out_proto_hdr_valid, if1.out_proto_hdr_sel,
                      if1.out_proto_hdr_length, if1.out_proto_hdr_pktlen, if1.out_proto_hdr_data,
                      if1.out_proto_hdr_tuser, if1.out_proto_hdr_meta, 2'd3);
            check_eq($sformatf("stall%0d_b4_sel", i), 128'({if4.out_proto_hdr_valid, if4.out_proto_hdr_sel}),
                     128'({1'b1, 2'd3}));
            check_eq($sformatf("stall%0d_ready", i),
                     128'({if1.in_proto_hdr_ready, if4.in_proto_hdr_ready}), 128'(0));
        end
        oready = 1'b1;
        #1;
        check_eq("unstall_ready", 128'({if1.in_proto_hdr_ready, if4.in_proto_hdr_ready}), 128'({4'b0001, 4'b0001}));
        step();
        check_out("nobubble_b1", if1.out_proto_hdr_valid, if1.out_proto_hdr_sel,
                  if1.out_proto_hdr_length, if1.out_proto_hdr_pktlen, if1.out_proto_hdr_data,
                  if1.out_proto_hdr_tuser, if1.out_proto_hdr_meta, 2'd0);
        check_out("nobubble_b4", if4.out_proto_hdr_valid, if4.out_proto_hdr_sel,
                  if4.out_proto_hdr_length, if4.out_proto_hdr_pktlen, if4.out_proto_hdr_data,
                  if4.out_proto_hdr_tuser, if4.out_proto_hdr_meta, 2'd0);

        // Idle while free: output drains, arbiter state holds.
        valid = 4'h0;
        step();
        check_eq("idle_valid", 128'({if1.out_proto_hdr_valid, if4.out_proto_hdr_valid}), 128'(0));
        check_eq("idle_state_b4", 128'({if4.dbg_last_grant, if4.dbg_burst_cnt}), 128'({2'd0, 8'd1}));
        check_eq("idle_state_b1", 128'({if1.dbg_last_grant, if1.dbg_burst_cnt}), 128'({2'd0, 8'd1}));

        // Reset mid-stream: async clear, then first grant to source 0.
        valid = 4'hF;
        step();
        check_eq("pre_rst_sel", 128'({if1.out_proto_hdr_valid, if1.out_proto_hdr_sel,
                                      if4.out_proto_hdr_valid, if4.out_proto_hdr_sel}),
                 128'({1'b1, 2'd1, 1'b1, 2'd0}));
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 128'({if1.out_proto_hdr_valid, if4.out_proto_hdr_valid}), 128'(0));
        check_eq("async_rst_ready", 128'({if1.in_proto_hdr_ready, if4.in_proto_hdr_ready}), 128'(0));
        step();
        rst = 1'b0;
        step();
        check_out("post_rst_b1", if1.out_proto_hdr_valid, if1.out_proto_hdr_sel,
                  if1.out_proto_hdr_length, if1.out_proto_hdr_pktlen, if1.out_proto_hdr_data,
                  if1.out_proto_hdr_tuser, if1.out_proto_hdr_meta, 2'd0);
        check_out("post_rst_b4", if4.out_proto_hdr_valid, if4.out_proto_hdr_sel,
                  if4.out_proto_hdr_length, if4.out_proto_hdr_pktlen, if4.out_proto_hdr_data,
                  if4.out_proto_hdr_tuser, if4.out_proto_hdr_meta, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
